// File: rtl/riscv_pkg.sv
// Shared types for the RV32I decode / ID-EX stage: ALU encoding, opcodes,
// operand/writeback select codes and the registered ID/EX bundle.
package riscv_pkg;

    localparam int XLEN_W   = 32;
    localparam int REG_AW_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [XLEN_W-1:0]   pc;
        alu_op_t             alu_control;
        logic [1:0]          src_a_sel;
        logic                src_b_imm;
        logic [XLEN_W-1:0]   imm;
        logic [REG_AW_W-1:0] rs1;
        logic [REG_AW_W-1:0] rs2;
        logic [REG_AW_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                branch_pol;
        logic                jump;
        logic [1:0]          result_src;
        logic                illegal;
    } id_ex_t;

    // alt selects SUB/SRA; callers decide when funct7[5] is meaningful.
    function automatic alu_op_t alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_ctrl_instr_decoder.sv
// Combinational RV32I decoder: control bundle, source-use flags and illegal
// detection. valid/pc/illegal fields of the bundle are left 0 for the caller.
module instr_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] i_instr,
    output id_ex_t      o_dec,
    output logic        o_rs1_used,
    output logic        o_rs2_used,
    output logic        o_illegal
);

    logic [6:0]        w_op;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic [XLEN_W-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_op = i_instr[6:0];
    assign w_f3 = i_instr[14:12];
    assign w_f7 = i_instr[31:25];

    assign w_imm_i = {{(XLEN_W-12){i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{(XLEN_W-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{(XLEN_W-13){i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{(XLEN_W-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        o_dec             = '0;
        o_dec.alu_control = ALU_ADD;
        o_dec.rs1         = i_instr[19:15];
        o_dec.rs2         = i_instr[24:20];
        o_dec.rd          = i_instr[11:7];
        o_rs1_used        = 1'b0;
        o_rs2_used        = 1'b0;
        o_illegal         = 1'b0;
        case (w_op)
            OPC_OP: begin
                o_rs1_used        = 1'b1;
                o_rs2_used        = 1'b1;
                o_dec.reg_write   = 1'b1;
                o_dec.alu_control = alu_dec(w_f3, w_f7[5]);
                if (!(w_f7 == 7'b0000000 ||
                      (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                    o_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                o_rs1_used        = 1'b1;
                o_dec.src_b_imm   = 1'b1;
                o_dec.imm         = w_imm_i;
                o_dec.reg_write   = 1'b1;
                // Only the right-shift form carries an alternate op in imm[10].
                o_dec.alu_control = alu_dec(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                if (w_f3 == 3'b001 && w_f7 != 7'b0000000)
                    o_illegal = 1'b1;
                if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000)
                    o_illegal = 1'b1;
            end
            OPC_LOAD: begin
                o_rs1_used       = 1'b1;
                o_dec.src_b_imm  = 1'b1;
                o_dec.imm        = w_imm_i;
                o_dec.mem_read   = 1'b1;
                o_dec.reg_write  = 1'b1;
                o_dec.result_src = RES_MEM;
                if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111)
                    o_illegal = 1'b1;
            end
            OPC_STORE: begin
                o_rs1_used      = 1'b1;
                o_rs2_used      = 1'b1;
                o_dec.src_b_imm = 1'b1;
                o_dec.imm       = w_imm_s;
                o_dec.mem_write = 1'b1;
                if (w_f3 > 3'b010)
                    o_illegal = 1'b1;
            end
            OPC_BRANCH: begin
                o_rs1_used   = 1'b1;
                o_rs2_used   = 1'b1;
                o_dec.branch = 1'b1;
                o_dec.imm    = w_imm_b;
                case (w_f3)
                    3'b000:  begin o_dec.alu_control = ALU_SUB;  o_dec.branch_pol = 1'b1; end
                    3'b001:  begin o_dec.alu_control = ALU_SUB;  o_dec.branch_pol = 1'b0; end
                    3'b100:  begin o_dec.alu_control = ALU_SLT;  o_dec.branch_pol = 1'b0; end
                    3'b101:  begin o_dec.alu_control = ALU_SLT;  o_dec.branch_pol = 1'b1; end
                    3'b110:  begin o_dec.alu_control = ALU_SLTU; o_dec.branch_pol = 1'b0; end
                    3'b111:  begin o_dec.alu_control = ALU_SLTU; o_dec.branch_pol = 1'b1; end
                    default: o_illegal = 1'b1;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                o_dec.src_a_sel = (w_op == OPC_LUI) ? SRC_A_ZERO : SRC_A_PC;
                o_dec.src_b_imm = 1'b1;
                o_dec.imm       = w_imm_u;
                o_dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                o_dec.src_a_sel  = SRC_A_PC;
                o_dec.src_b_imm  = 1'b1;
                o_dec.imm        = w_imm_j;
                o_dec.reg_write  = 1'b1;
                o_dec.jump       = 1'b1;
                o_dec.result_src = RES_PC4;
            end
            OPC_JALR: begin
                o_rs1_used       = 1'b1;
                o_dec.src_b_imm  = 1'b1;
                o_dec.imm        = w_imm_i;
                o_dec.reg_write  = 1'b1;
                o_dec.jump       = 1'b1;
                o_dec.result_src = RES_PC4;
                if (w_f3 != 3'b000)
                    o_illegal = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
        if (o_dec.rd == '0)
            o_dec.reg_write = 1'b0;
        if (o_illegal) begin
            o_dec.reg_write = 1'b0;
            o_dec.mem_read  = 1'b0;
            o_dec.mem_write = 1'b0;
            o_dec.branch    = 1'b0;
            o_dec.jump      = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_ctrl.sv
// Decode + ID/EX register with load-use hazard detection and bubble insertion.
// Define ID_ILLEGAL_TRAP_EN to carry illegal encodings into EX as a trap.
module id_ex_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_W,
    parameter int REG_AW = REG_AW_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              hazard_o,
    output logic              valid_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [3:0]        alu_control_o,
    output logic [1:0]        src_a_sel_o,
    output logic              src_b_imm_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              branch_o,
    output logic              branch_pol_o,
    output logic              jump_o,
    output logic [1:0]        result_src_o,
    output logic              illegal_o
);

    id_ex_t r_id_ex;
    id_ex_t w_dec;
    id_ex_t w_next;
    logic   w_rs1_used, w_rs2_used, w_illegal, w_hazard;

    instr_decoder u_dec (
        .i_instr    (instr_i),
        .o_dec      (w_dec),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used),
        .o_illegal  (w_illegal)
    );

    // Only a load in EX can't forward in time; x0 never carries a real result.
    assign w_hazard = valid_i && r_id_ex.valid && r_id_ex.mem_read &&
                      (r_id_ex.rd != '0) &&
                      ((w_rs1_used && (w_dec.rs1 == r_id_ex.rd)) ||
                       (w_rs2_used && (w_dec.rs2 == r_id_ex.rd))) &&
                      !flush_i && !stall_i;

    always_comb begin
        w_next = '0;
        if (valid_i && !w_illegal) begin
            w_next       = w_dec;
            w_next.valid = 1'b1;
            w_next.pc    = pc_i;
        end
`ifdef ID_ILLEGAL_TRAP_EN
        else if (valid_i) begin
            w_next.valid   = 1'b1;
            w_next.pc      = pc_i;
            w_next.illegal = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_id_ex <= '0;
        else if (flush_i)
            r_id_ex <= '0;
        else if (!stall_i) begin
            if (w_hazard)
                r_id_ex <= '0;
            else
                r_id_ex <= w_next;
        end
    end

    assign hazard_o      = w_hazard;
    assign valid_o       = r_id_ex.valid;
    assign pc_o          = r_id_ex.pc;
    assign alu_control_o = r_id_ex.alu_control;
    assign src_a_sel_o   = r_id_ex.src_a_sel;
    assign src_b_imm_o   = r_id_ex.src_b_imm;
    assign imm_o         = r_id_ex.imm;
    assign rs1_o         = r_id_ex.rs1;
    assign rs2_o         = r_id_ex.rs2;
    assign rd_o          = r_id_ex.rd;
    assign reg_write_o   = r_id_ex.reg_write;
    assign mem_read_o    = r_id_ex.mem_read;
    assign mem_write_o   = r_id_ex.mem_write;
    assign branch_o      = r_id_ex.branch;
    assign branch_pol_o  = r_id_ex.branch_pol;
    assign jump_o        = r_id_ex.jump;
    assign result_src_o  = r_id_ex.result_src;
    // Without the trap build the illegal bit is never loaded as 1.
    assign illegal_o     = r_id_ex.illegal;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Self-checking bench for id_ex_ctrl: decode vector table through a
// scoreboard queue, plus hand sequences for hazard, flush/stall and reset.
module tb_id_ex_ctrl;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [1:0]  sa;
        logic        sb;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, pol, jp;
        logic [1:0]  res;
        logic        ill;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic        vin;
        logic        ill;
        logic        vld;
        logic [3:0]  alu;
        logic [1:0]  sa;
        logic        sb;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, pol, jp;
        logic [1:0]  res;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic        vin = 1'b0, stall = 1'b0, flush = 1'b0;
    logic        hazard, valid_o, src_b_imm, reg_write, mem_read, mem_write;
    logic        branch, branch_pol, jump, illegal;
    logic [31:0] pc_o, imm;
    logic [3:0]  alu_control;
    logic [1:0]  src_a_sel, result_src;
    logic [4:0]  rs1, rs2, rd;

    int n_tests = 0;
    int n_fail  = 0;
    out_t sb_q[$];

    always #5 clk = ~clk;

    id_ex_ctrl dut (
        .clk(clk), .rst(rst), .instr_i(instr), .pc_i(pc), .valid_i(vin),
        .stall_i(stall), .flush_i(flush), .hazard_o(hazard), .valid_o(valid_o),
        .pc_o(pc_o), .alu_control_o(alu_control), .src_a_sel_o(src_a_sel),
        .src_b_imm_o(src_b_imm), .imm_o(imm), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .reg_write_o(reg_write), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .branch_o(branch), .branch_pol_o(branch_pol), .jump_o(jump),
        .result_src_o(result_src), .illegal_o(illegal)
    );

    function automatic out_t rd_out();
        out_t o;
        o = '{valid_o, pc_o, alu_control, src_a_sel, src_b_imm, imm, rs1, rs2, rd,
              reg_write, mem_read, mem_write, branch, branch_pol, jump, result_src, illegal};
        return o;
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input logic vi, input logic il,
                                input logic vl, input logic [3:0] a, input logic [1:0] sa_,
                                input logic sb_, input logic [31:0] im, input logic [4:0] rd_,
                                input logic [5:0] en, input logic [1:0] rs);
        vec_t v;
        v.instr = ins; v.vin = vi; v.ill = il; v.vld = vl; v.alu = a; v.sa = sa_;
        v.sb = sb_; v.imm = im; v.rd = rd_;
        {v.rw, v.mr, v.mw, v.br, v.pol, v.jp} = en;
        v.res = rs;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] p, input logic v);
        instr = ins; pc = p; vin = v;
    endtask

    vec_t vecs[14];

    initial begin
        out_t e, g, held;

        // enables order: rw mr mw br pol jp
        vecs[0]  = mk(32'h40B50533, 1, 0, 1, 4'b0001, 2'b00, 0, 32'h0,        5'd10, 6'b100000, 2'b00);
        vecs[1]  = mk(32'h40335293, 1, 0, 1, 4'b1001, 2'b00, 1, 32'h00000403, 5'd5,  6'b100000, 2'b00);
        vecs[2]  = mk(32'h0020D463, 1, 0, 1, 4'b0111, 2'b00, 0, 32'h8,        5'd8,  6'b000110, 2'b00);
        vecs[3]  = mk(32'h123450B7, 1, 0, 1, 4'b0000, 2'b10, 1, 32'h12345000, 5'd1,  6'b100000, 2'b00);
        vecs[4]  = mk(32'h00001117, 1, 0, 1, 4'b0000, 2'b01, 1, 32'h00001000, 5'd2,  6'b100000, 2'b00);
        vecs[5]  = mk(32'h010000EF, 1, 0, 1, 4'b0000, 2'b01, 1, 32'h10,       5'd1,  6'b100001, 2'b10);
        vecs[6]  = mk(32'h00008067, 1, 0, 1, 4'b0000, 2'b00, 1, 32'h0,        5'd0,  6'b000001, 2'b10);
        vecs[7]  = mk(32'h00532423, 1, 0, 1, 4'b0000, 2'b00, 1, 32'h8,        5'd8,  6'b001000, 2'b00);
        vecs[8]  = mk(32'hFFC32283, 1, 0, 1, 4'b0000, 2'b00, 1, 32'hFFFFFFFC, 5'd5,  6'b110000, 2'b01);
        vecs[9]  = mk(32'hFFF27193, 1, 0, 1, 4'b0010, 2'b00, 1, 32'hFFFFFFFF, 5'd3,  6'b100000, 2'b00);
        vecs[10] = mk(32'h00000063, 1, 0, 1, 4'b0001, 2'b00, 0, 32'h0,        5'd0,  6'b000110, 2'b00);
        vecs[11] = mk(32'h40001013, 1, 1, 0, 4'b0000, 2'b00, 0, 32'h0,        5'd0,  6'b000000, 2'b00);
        vecs[12] = mk(32'hFFFFFFFF, 1, 1, 0, 4'b0000, 2'b00, 0, 32'h0,        5'd0,  6'b000000, 2'b00);
        vecs[13] = mk(32'h40B50533, 0, 0, 0, 4'b0000, 2'b00, 0, 32'h0,        5'd0,  6'b000000, 2'b00);

        repeat (2) step();
        chk("reset_outputs", rd_out(), '0);
        chk("reset_hazard", {127'b0, hazard}, 128'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.instr, 32'h100 + 32'(4 * i), v.vin);
            e = '0;
            if (v.ill && v.vin) begin
`ifdef ID_ILLEGAL_TRAP_EN
                e.valid = 1'b1; e.pc = pc; e.ill = 1'b1;
`endif
            end else if (v.vld) begin
                e = '{1'b1, pc, v.alu, v.sa, v.sb, v.imm, v.instr[19:15], v.instr[24:20],
                      v.rd, v.rw, v.mr, v.mw, v.br, v.pol, v.jp, v.res, 1'b0};
            end
            sb_q.push_back(e);
            step();
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 128'd1, 128'd0);
            end else begin
                g = rd_out();
                e = sb_q.pop_front();
                chk($sformatf("vec%0d_%h", i, v.instr), g, e);
            end
        end

        // load-use: lw x5,0(x6) then add x7,x5,x1
        drive(32'h00032283, 32'h300, 1'b1);
        step();
        chk("lu_load_issued", {126'b0, valid_o, mem_read}, {126'b0, 2'b11});
        drive(32'h001283B3, 32'h304, 1'b1);
        #1 chk("lu_hazard_set", {127'b0, hazard}, 128'd1);
        step();
        chk("lu_bubble", {127'b0, valid_o}, 128'd0);
        chk("lu_hazard_once", {127'b0, hazard}, 128'd0);
        step();
        chk("lu_add_issue", {116'b0, valid_o, alu_control, rd, reg_write, pc_o[1:0]},
                            {116'b0, 1'b1, 4'b0000, 5'd7, 1'b1, 2'b00});

        // same shape with rd = x0: no hazard
        drive(32'h00032003, 32'h308, 1'b1);
        step();
        drive(32'h001003B3, 32'h30C, 1'b1);
        #1 chk("x0_no_hazard", {127'b0, hazard}, 128'd0);
        step();
        chk("x0_add_issue", {127'b0, valid_o}, 128'd1);

        // flush + stall with a dependent add behind a load
        drive(32'h00032283, 32'h310, 1'b1);
        step();
        drive(32'h001283B3, 32'h314, 1'b1);
        flush = 1'b1; stall = 1'b1;
        #1 chk("fs_hazard_masked", {127'b0, hazard}, 128'd0);
        step();
        chk("fs_bubble", rd_out(), '0);
        flush = 1'b0; stall = 1'b0;

        // stall holds for three cycles
        drive(32'h40B50533, 32'h320, 1'b1);
        step();
        held = '{1'b1, 32'h320, 4'b0001, 2'b00, 1'b0, 32'h0, 5'd10, 5'd11, 5'd10,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        chk("stall_load", rd_out(), held);
        stall = 1'b1;
        drive(32'hFFF27193, 32'h324, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall_hold%0d", k), rd_out(), held);
        end
        stall = 1'b0;

        // asynchronous reset mid-cycle, then first instruction after release
        @(negedge clk);
        rst = 1'b1;
        #1 chk("async_reset", rd_out(), '0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h40335293, 32'h400, 1'b1);
        #1 chk("post_reset_idle", {127'b0, valid_o}, 128'd0);
        step();
        chk("post_reset_first", {95'b0, valid_o, pc_o}, {95'b0, 1'b1, 32'h400});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_ctrl.md
Name: id_ex_ctrl

Overview:
- Decode and ID/EX pipeline stage; the producer side of the ALU control interface.
- Decodes a 32-bit RV32I instruction into ALU control, operand selects, immediate and datapath enables.
- Registers the decoded bundle into the ID/EX register and detects load-use hazards against the instruction already in EX.
- Inserts a bubble when a load-use hazard, a flush or an illegal instruction occurs.
- Sits between the IF/ID register and the EX stage (ALU, branch compare).

Parameters:
- XLEN, 32, datapath and immediate width.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_i  in  32  instruction from IF/ID.
- pc_i  in  XLEN  PC of instr_i.
- valid_i  in  1  instr_i is a real instruction.
- stall_i  in  1  downstream stall: hold ID/EX contents.
- flush_i  in  1  branch/jump redirect: kill the ID instruction.
- hazard_o  out  1  combinational load-use stall request to IF/ID and PC.
- valid_o  out  1  EX-stage instruction valid.
- pc_o  out  XLEN  registered PC.
- alu_control_o  out  4  ALU opcode, encoding from the package.
- src_a_sel_o  out  2  ALU operand A select: 00 rs1, 01 PC, 10 zero.
- src_b_imm_o  out  1  ALU operand B select: 1 immediate, 0 rs2.
- imm_o  out  XLEN  sign-extended immediate.
- rs1_o, rs2_o, rd_o  out  REG_AW each  register indices.
- reg_write_o, mem_read_o, mem_write_o  out  1 each  datapath enables.
- branch_o  out  1  conditional branch.
- branch_pol_o  out  1  branch taken when ALU zero_o equals this bit.
- jump_o  out  1  JAL/JALR.
- result_src_o  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
- illegal_o  out  1  registered illegal-instruction flag.

Behaviour:
- Reset: all registered outputs are 0. This gives valid_o=0, alu_control_o=ADD (0000), all enables 0 and imm_o=0. Reset asserted mid-operation clears the register immediately.
- Latency: 1 cycle. A decode captured at edge N is visible after edge N.
- Update priority per edge: rst, then flush_i (bubble), then stall_i (hold), then hazard_o (bubble), then load the decode.
- Bubble: valid_o=0; reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o and illegal_o are all 0. Other fields are don't-care and are loaded as 0.
- hazard_o is 1 when all of the following hold: valid_i; registered valid_o; mem_read_o; rd_o≠0; and rd_o matches a source the instruction actually uses.
  - rs1 is used by R, I-ALU, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by R, STORE and BRANCH.
  - hazard_o is forced to 0 when flush_i or stall_i is high.
- ALU encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SLT 0111, SLTU 1000, SRA 1001.
- Opcode decode:
  - R: funct3/funct7[5] select the ALU op.
  - I-ALU: same selection, but funct7[5] is honoured only for SRAI. ADDI never decodes as SUB.
  - LOAD/STORE: ADD with immediate.
  - LUI: ADD, A=zero. AUIPC: ADD, A=PC.
  - JAL/JALR: result_src=10, jump_o=1. Target add is ADD with A=PC (JAL) or A=rs1 (JALR).
- Branches:
  - BEQ: SUB, pol 1. BNE: SUB, pol 0.
  - BLT: SLT, pol 0. BGE: SLT, pol 1.
  - BLTU: SLTU, pol 0. BGEU: SLTU, pol 1.
- Immediates are I, S, B, U and J formats, sign-extended to XLEN.
- reg_write_o is 0 when rd=0.
- Illegal encodings: unknown opcode, reserved funct3, bad funct7, or bad shift funct7.
- valid_i=0 loads a bubble unless stall_i is high.

Optional Feature:
- Macro: ID_ILLEGAL_TRAP_EN.
- Defined: illegal encodings set illegal_o=1 with valid_o=1; all enables are 0.
- Undefined: illegal encodings load a bubble; illegal_o is tied to 0.

Decomposition:
- Package riscv_pkg holds:
  - alu_op_t enum (4-bit encoding above);
  - opcode constants;
  - src_a_sel and result_src constants;
  - id_ex_t packed struct for the registered bundle.
- One combinational sub-module, instr_decoder: produces id_ex_t and the rs-used flags from instr_i.
- The top level keeps the register, priority logic and hazard compare.

Test Plan:
- Reset: rst=1 mid-stream → all outputs 0 asynchronously. First valid instruction after release appears one cycle later.
- 0x40B50533 (sub a0,a0,a1) → alu_control_o=0001, src_b_imm_o=0, rd_o=10, reg_write_o=1, valid_o=1.
- 0x40335293 (srai x5,x6,3) → alu_control_o=1001, src_b_imm_o=1, imm_o[4:0]=3.
- 0x00032283 (lw x5,0(x6)) followed by 0x001283B3 (add x7,x5,x1):
  - hazard_o=1 for exactly one cycle, then one bubble (valid_o=0).
  - The add then issues with alu_control_o=0000.
  - Repeat with rd=x0 → no hazard.
- 0x0020D463 (bge x1,x2,8) → alu_control_o=0111, branch_o=1, branch_pol_o=1, imm_o=8, reg_write_o=0.
- flush_i and stall_i together with a valid add → bubble loaded, hazard_o=0. stall_i alone → outputs unchanged across 3 cycles. 0xFFFFFFFF → illegal_o per ID_ILLEGAL_TRAP_EN.
